// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter; define PS2_TX_FILTER_EN for 8-cycle input glitch filtering
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 1_300_000
) (
  input  logic       clk65,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] SHIFT     = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_f, data_f, clk_prev, fall;
  logic [2:0]  state;
  logic [12:0] inh_cnt;
  logic [20:0] to_cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  data_q;
  logic        data_oe_q;
  logic [9:0]  frame;
  // two-flop synchronizers, reset to the released (high) level so reset never fakes an edge
  always_ff @(posedge clk65 or posedge rst)
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
`ifdef PS2_TX_FILTER_EN
  logic [2:0] clk_run, data_run;
  // filtered level follows the synced level only after it has differed for 8 consecutive cycles
  always_ff @(posedge clk65 or posedge rst)
    if (rst) begin
      clk_f    <= 1'b1;
      data_f   <= 1'b1;
      clk_run  <= '0;
      data_run <= '0;
    end else begin
      clk_run  <= (clk_sync[1] == clk_f) ? 3'd0 : clk_run + 3'd1;
      data_run <= (data_sync[1] == data_f) ? 3'd0 : data_run + 3'd1;
      if (clk_sync[1] != clk_f && clk_run == 3'd7) clk_f <= clk_sync[1];
      if (data_sync[1] != data_f && data_run == 3'd7) data_f <= data_sync[1];
    end
`else
  assign clk_f  = clk_sync[1];
  assign data_f = data_sync[1];
`endif
  // previous clock level for falling-edge detection
  always_ff @(posedge clk65 or posedge rst)
    if (rst) clk_prev <= 1'b1;
    else clk_prev <= clk_f;
  assign fall  = clk_prev & ~clk_f;
  assign frame = {1'b1, ~^data_q, data_q};
  // transaction sequencer: inhibit, request, shift 10 bits, check ACK, wait for bus idle
  always_ff @(posedge clk65 or posedge rst)
    if (rst) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      data_oe_q <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE:
          if (tx_start) begin
            state   <= INHIBIT;
            data_q  <= tx_data;
            inh_cnt <= '0;
          end
        INHIBIT:
          if (inh_cnt == 13'(INHIBIT_CYCLES - 1)) begin
            state     <= REQ;
            data_oe_q <= 1'b1;
          end else inh_cnt <= inh_cnt + 13'd1;
        REQ: begin
          state   <= SHIFT;
          to_cnt  <= '0;
          bit_idx <= '0;
        end
        default:
          if (to_cnt == 21'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            data_oe_q <= 1'b0;
            tx_error  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 21'd1;
            if (state == SHIFT && fall) begin
              data_oe_q <= ~frame[bit_idx];
              bit_idx   <= (bit_idx == 4'd9) ? bit_idx : bit_idx + 4'd1;
              if (bit_idx == 4'd9) state <= ACK;
            end else if (state == ACK && fall) begin
              state    <= data_f ? IDLE : WAIT_IDLE;
              tx_error <= data_f;
            end else if (state == WAIT_IDLE && clk_f && data_f) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end
          end
      endcase
    end
  assign tx_busy     = state != IDLE;
  assign ps2_clk_oe  = state == INHIBIT || state == REQ;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with a behavioural PS/2 device on wired-AND lines
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TMO = 3000;
  localparam int H   = 20;
  typedef struct {
    int         kind;
    logic [9:0] frame;
  } exp_t;
  logic       clk65 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       clk_line, data_line;
  logic [9:0] rx_frame = '0;
  logic       prev_clk_oe = 1'b0;
  exp_t       q[$];
  int         compared = 0, mismatched = 0;
  int         cyc = 0, rel_cyc = 0, inh_n = 0, ovl_n = 0;

  assign clk_line  = ~ps2_clk_oe & ~dev_clk_low;
  assign data_line = ~ps2_data_oe & ~dev_data_low;

  always #5 clk65 = ~clk65;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk65(clk65), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected wire frame: data LSB first, then odd parity, then stop
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    return {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // device: waits for a request, clocks out 11 pulses, samples host bits on rising edges
  // mode 0 ACK, 1 no ACK, 2 never clocks, 3 stops after 5 pulses, 4 ACK plus a short clock glitch
  task automatic device(input int mode);
    int w = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && w < INH + 50) begin
      @(negedge clk65);
      w++;
    end
    if (w >= INH + 50) begin
      check("request_seen", 0, 1);
      return;
    end
    check("start_bit", int'(data_line), 0);
    if (mode == 2) return;
    repeat (H) @(negedge clk65);
    rx_frame = '0;
    for (int k = 0; k < 11; k++) begin
      if (mode == 3 && k == 5) return;
      if (k == 10 && mode != 1) begin
        dev_data_low = 1'b1;
        repeat (4) @(negedge clk65);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk65);
      dev_clk_low = 1'b0;
      if (k < 10) rx_frame[k] = data_line;
      dev_data_low = 1'b0;
      if (mode == 4 && k == 2) begin
        repeat (6) @(negedge clk65);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk65);
        dev_clk_low = 1'b0;
        repeat (H - 11) @(negedge clk65);
      end else repeat (H) @(negedge clk65);
    end
  endtask

  // stimulus: push the expected outcome, issue the request, optionally poke 0x55 while busy
  task automatic send(input logic [7:0] b, input int mode, input bit poke);
    exp_t e;
    int   w = 0;
    if (mode != 3) begin
      e.kind  = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
      e.frame = model_frame(b);
      q.push_back(e);
    end
    @(negedge clk65);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk65);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    fork
      device(mode);
      if (poke) begin
        repeat (INH + 3 * H) @(negedge clk65);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk65);
        tx_start = 1'b0;
      end
    join
    if (mode == 3) return;
    while (tx_busy && w < TMO + 100) begin
      @(negedge clk65);
      w++;
    end
    check("busy_released", int'(tx_busy), 0);
    repeat (5) @(negedge clk65);
    check("stays_idle", int'(tx_busy), 0);
  endtask

  // monitor: inhibit/overlap timing, then pops the scoreboard on every done/error pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk65);
      cyc++;
      if (ps2_clk_oe && !ps2_data_oe) inh_n++;
      if (ps2_clk_oe && ps2_data_oe) ovl_n++;
      if (prev_clk_oe && !ps2_clk_oe) begin
        rel_cyc = cyc;
        check("inhibit_len", inh_n, INH);
        check("req_overlap", ovl_n, 1);
        inh_n = 0;
        ovl_n = 0;
      end
      prev_clk_oe = ps2_clk_oe;
      if (tx_done || tx_error) begin
        check("done_error_excl", int'(tx_done && tx_error), 0);
        check("busy_at_pulse", int'(tx_busy), 0);
        check("oe_at_pulse", int'({ps2_clk_oe, ps2_data_oe}), 0);
        if (q.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          e = q.pop_front();
          check("outcome_error", int'(tx_error), int'(e.kind != 0));
          if (e.kind != 2) check("frame", int'(rx_frame), int'(e.frame));
          else check("timeout_latency", cyc - rel_cyc, TMO);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk65);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_error", int'(tx_error), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk65);
    send(8'hF4, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 0, 1'b0);
    for (int i = 0; i < 2; i++) send(8'($urandom), 1, 1'b0);
    send(8'($urandom), 0, 1'b1);
    send(8'($urandom), 2, 1'b1);
    b = 8'($urandom) & 8'hEF;
    send(b, 3, 1'b0);
    check("pre_rst_data_oe", int'(ps2_data_oe), 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_clk_oe", int'(ps2_clk_oe), 0);
    check("async_rst_data_oe", int'(ps2_data_oe), 0);
    check("async_rst_busy", int'(tx_busy), 0);
    @(negedge clk65);
    rst = 1'b0;
    repeat (50) @(negedge clk65);
    check("post_rst_busy", int'(tx_busy), 0);
    send(8'($urandom), 0, 1'b0);
`ifdef PS2_TX_FILTER_EN
    send(8'($urandom), 4, 1'b0);
`endif
    repeat (20) @(negedge clk65);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
